// File: rtl/piso_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_arb_pkg
//  Description : Shared constants for the arbitrated 4-bit PISO serialiser:
//                FSM state encoding, frame length, start-bit level and the
//                round-robin winner selection helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_arb_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;

    // One start bit plus four payload bits
    localparam int   FRAME_BITS = 5;
    localparam logic START_LVL  = 1'b1;

    // Winner index for a non-zero request vector: a lone request always wins,
    // a tie goes to the requester that was not granted last.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        logic win;
        if (req == 2'b11) begin
            win = ~last;
        end else begin
            win = req[1];
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso4_shift.sv
`default_nettype none
// ============================================================================
//  Module      : piso4_shift
//  Description : 4-bit parallel-load shift register, shifting toward bit 0
//                with zero fill; bit 0 is presented as the serial output.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso4_shift (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       shift,
    input  logic [3:0] d,
    output logic       bit0
);

    logic [3:0] r_sr;

    // Load has priority over shift; shifting feeds zeros in from the top
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr <= 4'b0000;
        end else if (load) begin
            r_sr <= d;
        end else if (shift) begin
            r_sr <= {1'b0, r_sr[3:1]};
        end
    end

    assign bit0 = r_sr[0];

endmodule
`default_nettype wire

// File: rtl/piso_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : piso_arb_ctrl
//  Description : Two-requester round-robin arbiter feeding a serialiser.
//                Each accepted frame is one START_LVL start bit followed by
//                the winner's 4-bit payload LSB first, every bit held for
//                BIT_CYC clocks. Outputs are registered, so the wire-level
//                frame trails the FSM by one clock: gnt appears in the first
//                START cycle, q/busy follow one cycle later, and done marks
//                the first cycle after the last payload bit leaves q.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_arb_ctrl #(
    parameter int BIT_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] data0,
    input  logic [3:0] data1,
    output logic [1:0] gnt,
    output logic       q,
    output logic       busy,
    output logic       done
);

    import piso_arb_pkg::*;

    localparam logic [3:0] c_cyc_last = 4'(BIT_CYC - 1);
    localparam logic [2:0] c_bit_last = 3'(FRAME_BITS - 1);

    logic [1:0] r_state;
    logic [3:0] r_cyc;
    logic [2:0] r_bit;
    logic       r_last;
    logic [1:0] r_gnt;
    logic       r_q;
    logic       r_busy;
    logic       r_done;

    logic       w_req_any;
    logic       w_win;
    logic       w_cyc_end;
    logic       w_bit_end;
    logic       w_load;
    logic       w_shift;
    logic [3:0] w_data;
    logic       w_sr_bit0;

    // Arbitration and counter-terminal decodes
    always_comb begin
        w_req_any = |req;
        w_win     = rr_pick(req, r_last);
        w_cyc_end = (r_cyc == c_cyc_last);
        w_bit_end = (r_bit == c_bit_last);
        w_load    = (r_state == S_IDLE) && w_req_any;
        w_shift   = (r_state == S_DATA) && w_cyc_end;
        w_data    = w_win ? data1 : data0;
    end

    piso4_shift u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .shift (w_shift),
        .d     (w_data),
        .bit0  (w_sr_bit0)
    );

    // Frame sequencing: bit counter 0 is the start bit, 1..4 the payload
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cyc   <= 4'd0;
            r_bit   <= 3'd0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_state <= S_START;
                        r_cyc   <= 4'd0;
                        r_bit   <= 3'd0;
                        r_last  <= w_win;
                    end
                end
                S_START, S_DATA: begin
                    if (w_cyc_end) begin
                        r_cyc <= 4'd0;
                        if (w_bit_end) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_cyc <= r_cyc + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Registered outputs; done fires when busy drops with the FSM back in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt  <= 2'b00;
            r_q    <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_gnt  <= w_load ? (w_win ? 2'b10 : 2'b01) : 2'b00;
            r_busy <= (r_state != S_IDLE);
            r_done <= r_busy && (r_state == S_IDLE);
            case (r_state)
                S_START: r_q <= START_LVL;
                S_DATA:  r_q <= w_sr_bit0;
                default: r_q <= 1'b0;
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign q    = r_q;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_arb_ctrl
//  Description : Self-checking bench for piso_arb_ctrl. Two instances
//                (BIT_CYC=1 and BIT_CYC=3); per-cycle expected outputs are
//                queued when stimulus is applied and popped each clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_arb_ctrl;

    typedef struct {
        logic [1:0] gnt;
        logic       q;
        logic       busy;
        logic       done;
    } exp_t;

    typedef struct {
        logic [1:0] req;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [1:0] exp_gnt;
        logic [3:0] exp_pay;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req1, req3;
    logic [3:0] d0_1, d1_1, d0_3, d1_3;
    logic [1:0] gnt1, gnt3;
    logic       q1, q3, busy1, busy3, done1, done3;

    exp_t  exp1[$];
    exp_t  exp3[$];
    vec_t  vecs[7];
    int    checks = 0;
    int    errors = 0;
    string cur_tag = "reset";

    always #5 clk = ~clk;

    piso_arb_ctrl #(.BIT_CYC(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .data0(d0_1), .data1(d1_1),
        .gnt(gnt1), .q(q1), .busy(busy1), .done(done1)
    );

    piso_arb_ctrl #(.BIT_CYC(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3), .data0(d0_3), .data1(d1_3),
        .gnt(gnt3), .q(q3), .busy(busy3), .done(done3)
    );

    task automatic push(input int which, input logic [1:0] g, input logic qq,
                        input logic b, input logic dn);
        exp_t e;
        e.gnt = g; e.q = qq; e.busy = b; e.done = dn;
        if (which == 1) exp1.push_back(e); else exp3.push_back(e);
    endtask

    // Expected wire activity of one frame; b2b merges the grant into the
    // previous frame's done cycle
    task automatic push_frame(input int which, input logic [1:0] g,
                              input logic [3:0] pay, input int bc, input bit b2b);
        exp_t e;
        if (b2b) begin
            if (which == 1) e = exp1.pop_back(); else e = exp3.pop_back();
            e.gnt = g;
            if (which == 1) exp1.push_back(e); else exp3.push_back(e);
        end else begin
            push(which, g, 1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < bc; k++) push(which, 2'b00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < bc; k++) push(which, 2'b00, pay[i], 1'b1, 1'b0);
        push(which, 2'b00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic cmp(input string name, input exp_t e, input logic [1:0] g,
                       input logic qq, input logic b, input logic dn);
        checks++;
        if ({g, qq, b, dn} !== {e.gnt, e.q, e.busy, e.done}) begin
            errors++;
            $display("FAIL %s %s @%0t: got gnt=%b q=%b busy=%b done=%b, expected gnt=%b q=%b busy=%b done=%b",
                     cur_tag, name, $time, g, qq, b, dn, e.gnt, e.q, e.busy, e.done);
        end
    endtask

    // Advance one clock and compare both instances against their queues
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp1.size() > 0) begin
            e = exp1.pop_front();
            cmp("dut1", e, gnt1, q1, busy1, done1);
        end
        if (exp3.size() > 0) begin
            e = exp3.pop_front();
            cmp("dut3", e, gnt3, q3, busy3, done3);
        end
    endtask

    task automatic drain();
        while (exp1.size() > 0 || exp3.size() > 0) tick();
    endtask

    task automatic chk_zero(input string name, input logic [4:0] act);
        checks++;
        if (act !== 5'b0) begin
            errors++;
            $display("FAIL %s %s: got {gnt,q,busy,done}=%b, expected 00000", cur_tag, name, act);
        end
    endtask

    initial begin
        vecs[0] = '{req: 2'b01, d0: 4'b1011, d1: 4'b0000, exp_gnt: 2'b01, exp_pay: 4'b1011};
        vecs[1] = '{req: 2'b11, d0: 4'b0101, d1: 4'b1110, exp_gnt: 2'b10, exp_pay: 4'b1110};
        vecs[2] = '{req: 2'b11, d0: 4'b0011, d1: 4'b1001, exp_gnt: 2'b01, exp_pay: 4'b0011};
        vecs[3] = '{req: 2'b10, d0: 4'b1111, d1: 4'b0110, exp_gnt: 2'b10, exp_pay: 4'b0110};
        vecs[4] = '{req: 2'b01, d0: 4'b0000, d1: 4'b1111, exp_gnt: 2'b01, exp_pay: 4'b0000};
        vecs[5] = '{req: 2'b10, d0: 4'b1010, d1: 4'b1111, exp_gnt: 2'b10, exp_pay: 4'b1111};
        vecs[6] = '{req: 2'b11, d0: 4'b1000, d1: 4'b0001, exp_gnt: 2'b01, exp_pay: 4'b1000};

        rst  = 1'b0;
        req1 = 2'b00; d0_1 = 4'h0; d1_1 = 4'h0;
        req3 = 2'b00; d0_3 = 4'h0; d1_3 = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("dut1_reset", {gnt1, q1, busy1, done1});
        chk_zero("dut3_reset", {gnt3, q3, busy3, done3});
        rst = 1'b1;

        // Tie held from reset: grants alternate starting with requester 0
        cur_tag = "rr_held";
        req1 = 2'b11; d0_1 = 4'b1010; d1_1 = 4'b0111;
        push_frame(1, 2'b01, 4'b1010, 1, 1'b0);
        push_frame(1, 2'b10, 4'b0111, 1, 1'b1);
        push_frame(1, 2'b01, 4'b1010, 1, 1'b1);
        repeat (13) tick();
        req1 = 2'b00;
        push(1, 2'b00, 1'b0, 1'b0, 1'b0);
        push(1, 2'b00, 1'b0, 1'b0, 1'b0);
        drain();

        // Single-cycle requests from IDLE; payload scrambled after grant
        for (int v = 0; v < 7; v++) begin
            cur_tag = $sformatf("vec%0d", v);
            req1 = vecs[v].req; d0_1 = vecs[v].d0; d1_1 = vecs[v].d1;
            push_frame(1, vecs[v].exp_gnt, vecs[v].exp_pay, 1, 1'b0);
            push(1, 2'b00, 1'b0, 1'b0, 1'b0);
            push(1, 2'b00, 1'b0, 1'b0, 1'b0);
            tick();
            req1 = 2'b00;
            d0_1 = ~vecs[v].d0; d1_1 = ~vecs[v].d1;
            drain();
        end

        // Payload change one cycle after the grant
        cur_tag = "payload_hold";
        req1 = 2'b01; d0_1 = 4'b1011;
        push_frame(1, 2'b01, 4'b1011, 1, 1'b0);
        push(1, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        req1 = 2'b00;
        tick();
        d0_1 = 4'b0000;
        drain();

        // Three clocks per bit
        cur_tag = "bitcyc3";
        req3 = 2'b10; d1_3 = 4'b0110;
        push_frame(3, 2'b10, 4'b0110, 3, 1'b0);
        push(3, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        req3 = 2'b00;
        drain();

        // Asynchronous reset during the third payload bit
        cur_tag = "reset_mid";
        req1 = 2'b01; d0_1 = 4'b1101;
        push_frame(1, 2'b01, 4'b1101, 1, 1'b0);
        tick();
        req1 = 2'b00;
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        chk_zero("dut1_async", {gnt1, q1, busy1, done1});
        exp1.delete();
        @(posedge clk);
        #1;
        chk_zero("dut1_held", {gnt1, q1, busy1, done1});
        rst = 1'b1;
        cur_tag = "post_reset";
        push(1, 2'b00, 1'b0, 1'b0, 1'b0);
        push(1, 2'b00, 1'b0, 1'b0, 1'b0);
        drain();
        req1 = 2'b01; d0_1 = 4'b0110;
        push_frame(1, 2'b01, 4'b0110, 1, 1'b0);
        push(1, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        req1 = 2'b00;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
